// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states,
// instruction fields, ALU operations and datapath mux selects.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_WB_MEM   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_WB_R     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_HALT     = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_J,
        CLS_ILL
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/mips_mc_decode.sv
// Combinational instruction classifier: maps opcode/funct to an instruction
// class, the R-type ALU operation and a legality flag.
module mips_mc_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_t    iclass,
    output logic [2:0] alu_op,
    output logic       legal
);

    always_comb begin
        iclass = CLS_ILL;
        alu_op = ALU_ADD;
        legal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                iclass = CLS_R;
                legal  = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    default: begin
                        iclass = CLS_ILL;
                        legal  = 1'b0;
                    end
                endcase
            end
            OP_LW:  begin iclass = CLS_LW;  legal = 1'b1; end
            OP_SW:  begin iclass = CLS_SW;  legal = 1'b1; end
            OP_BEQ: begin iclass = CLS_BEQ; legal = 1'b1; end
            OP_J:   begin iclass = CLS_J;   legal = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM with memory-wait timeout, sticky error flags
// and a retired-instruction counter.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int WAIT_MAX = 15
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        ir_write,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic [3:0]  state,
    output logic        illegal,
    output logic        timeout,
    output logic [31:0] instr_count
);

    localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    state_t            cur_state;
    state_t            next_state;
    iclass_t           iclass;
    logic [2:0]        dec_alu_op;
    logic              legal;
    logic [WAIT_W-1:0] wait_cnt;
    logic [31:0]       count_q;
    logic              mem_state;
    logic              wait_expire;
    logic              retire;

    mips_mc_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .iclass (iclass),
        .alu_op (dec_alu_op),
        .legal  (legal)
    );

    assign state       = cur_state;
    assign instr_count = count_q;

    // wait_cnt holds the number of stalled cycles already spent in this state
    assign mem_state   = (cur_state == S_FETCH) || (cur_state == S_MEM_RD) ||
                         (cur_state == S_MEM_WR);
    assign wait_expire = mem_state && !mem_ready && (wait_cnt == WAIT_LAST);
    assign retire      = (cur_state == S_WB_MEM) || (cur_state == S_WB_R) ||
                         (cur_state == S_BRANCH) || (cur_state == S_JUMP) ||
                         ((cur_state == S_MEM_WR) && mem_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            count_q  <= '0;
            illegal  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            if (mem_state && !mem_ready && !wait_expire) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (retire) begin
                count_q <= count_q + 32'd1;
            end
            if ((cur_state == S_DECODE) && !legal) begin
                illegal <= 1'b1;
            end
            if (wait_expire) begin
                timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            S_FETCH: begin
                if (mem_ready)        next_state = S_DECODE;
                else if (wait_expire) next_state = S_HALT;
            end
            S_DECODE: begin
                case (iclass)
                    CLS_R:          next_state = S_EXEC_R;
                    CLS_LW, CLS_SW: next_state = S_MEM_ADDR;
                    CLS_BEQ:        next_state = S_BRANCH;
                    CLS_J:          next_state = S_JUMP;
                    default:        next_state = S_HALT;
                endcase
                if (!legal) next_state = S_HALT;
            end
            S_MEM_ADDR: next_state = (iclass == CLS_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready)        next_state = S_WB_MEM;
                else if (wait_expire) next_state = S_HALT;
            end
            S_MEM_WR: begin
                if (mem_ready)        next_state = S_FETCH;
                else if (wait_expire) next_state = S_HALT;
            end
            S_WB_MEM: next_state = S_FETCH;
            S_EXEC_R: next_state = S_WB_R;
            S_WB_R:   next_state = S_FETCH;
            S_BRANCH: next_state = S_FETCH;
            S_JUMP:   next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_HALT;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        pc_src     = PC_ALU;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_AND;
        case (cur_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                alu_op    = ALU_ADD;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = dec_alu_op;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PC_ALUOUT;
                pc_write  = zero;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_JUMP;
            end
            default: ;
        endcase
        // The reset state is FETCH, so its strobes must be held off while reset is low
        if (!rst) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

endmodule
